// File: rtl/rc_pulse_decoder_if.sv
// rc_pulse_decoder_if: PWM input and decoded position/status bundle of the RC pulse decoder
interface rc_pulse_decoder_if;
   logic       pulse_in;
   logic [7:0] position;
   logic       valid;
   logic       range_err;
   logic       signal_lost;
   modport master (output pulse_in, input position, valid, range_err, signal_lost);
   modport slave (input pulse_in, output position, valid, range_err, signal_lost);
endinterface

// File: rtl/rc_pulse_decoder.sv
// rc_pulse_decoder: measures the high time of an RC PWM input in ticks and recovers its 8-bit position
module rc_pulse_decoder #(
   parameter int CLK_DIV        = 392,
   parameter int MIN_TICKS      = 256,
   parameter int MAX_HIGH_TICKS = 1023,
   parameter int TIMEOUT_TICKS  = 8192
) (
   input logic               clk,
   input logic               rst,
   rc_pulse_decoder_if.slave bus
);
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PRE_HALF = PW'(CLK_DIV / 2);
   localparam logic [10:0] W_LO = 11'(MIN_TICKS);
   localparam logic [10:0] W_HI = 11'(MIN_TICKS + 255);
   localparam logic [9:0] W_MAX = 10'(MAX_HIGH_TICKS);
   localparam logic [13:0] TO_MAX = 14'(TIMEOUT_TICKS);
   localparam logic [1:0] ARM = 2'd0, IDLE = 2'd1, HIGH = 2'd2, STUCK = 2'd3;
   logic sync_0, sync_1, sync_1_d;
   logic [PW-1:0] presc;
   logic [9:0] width_cnt;
   logic [13:0] to_cnt;
   logic [1:0] state, state_nx;
   logic tick, rise, fall, dec, range_nx;
   logic [10:0] width_eff;
   logic [7:0] position, position_nx;
   logic valid, range_err, signal_lost;
   assign bus.position    = position;
   assign bus.valid       = valid;
   assign bus.range_err   = range_err;
   assign bus.signal_lost = signal_lost;
   // The tick landing in the falling-edge cycle still belongs to the pulse, giving round-to-nearest.
   always_comb begin
      tick        = presc == PRE_LAST;
      rise        = sync_1 & ~sync_1_d;
      fall        = ~sync_1 & sync_1_d;
      dec         = state == HIGH && fall;
      width_eff   = {1'b0, width_cnt} + {10'd0, tick};
      range_nx    = width_eff < W_LO || width_eff > W_HI;
      position_nx = width_eff < W_LO ? 8'h00 : width_eff > W_HI ? 8'hFF : 8'(width_eff - W_LO);
      state_nx    = state == ARM  ? (sync_1 ? ARM : IDLE)
                  : state == IDLE ? (rise ? HIGH : IDLE)
                  : state == HIGH ? (fall ? IDLE : width_cnt == W_MAX ? STUCK : HIGH)
                  : (sync_1 ? STUCK : IDLE);
   end
   // Synchronizer resets high so a pulse already in progress at release looks old and is skipped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) {sync_0, sync_1, sync_1_d} <= 3'b111;
      else {sync_0, sync_1, sync_1_d} <= {bus.pulse_in, sync_0, sync_1};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARM;
         presc       <= '0;
         width_cnt   <= '0;
         to_cnt      <= '0;
         position    <= 8'h80;
         valid       <= 1'b0;
         range_err   <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         state       <= state_nx;
         presc       <= rise ? PRE_HALF : tick ? '0 : presc + 1'b1;
         width_cnt   <= rise ? '0 : (state == HIGH && sync_1 && tick && width_cnt != W_MAX) ? width_cnt + 1'b1 : width_cnt;
         to_cnt      <= dec ? '0 : (tick && to_cnt != TO_MAX) ? to_cnt + 1'b1 : to_cnt;
         signal_lost <= dec ? 1'b0 : to_cnt == TO_MAX ? 1'b1 : signal_lost;
         valid       <= dec;
         position    <= dec ? position_nx : position;
         range_err   <= dec ? range_nx : range_err;
      end
   end
endmodule

// File: tb/tb_rc_pulse_decoder.sv
// tb_rc_pulse_decoder: randomized and directed checks of the RC pulse decoder against a width-law model
module tb_rc_pulse_decoder;
   localparam int D = 4, MIN = 256, MAXH = 1023, TO = 1500;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0;
   rc_pulse_decoder_if bus ();
   rc_pulse_decoder #(.CLK_DIV(D), .MIN_TICKS(MIN), .MAX_HIGH_TICKS(MAXH), .TIMEOUT_TICKS(TO))
      dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   function automatic void model(input int h, output logic [7:0] pos, output logic re);
      int w;
      w = (h + D / 2) / D;
      re = w < MIN || w > MIN + 255;
      pos = w < MIN ? 8'h00 : w > MIN + 255 ? 8'hFF : 8'(w - MIN);
   endfunction

   // Drives h clocks high then l clocks low, recording the last valid strobe seen.
   task automatic pulse(input int h, input int l, output int nv, output int lat,
                        output logic [7:0] pos, output logic re, output logic sl);
      nv = 0; lat = -1; pos = bus.position; re = bus.range_err; sl = bus.signal_lost;
      bus.pulse_in = 1'b1;
      for (int i = 1; i <= h; i++) begin
         @(posedge clk); #1;
         if (bus.valid) nv++;
      end
      bus.pulse_in = 1'b0;
      for (int i = 1; i <= l; i++) begin
         @(posedge clk); #1;
         if (bus.valid) begin
            nv++; lat = i; pos = bus.position; re = bus.range_err; sl = bus.signal_lost;
         end
      end
   endtask

   task automatic test_reset;
      bus.pulse_in = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.position !== 8'h80) begin errors++; $display("FAIL reset_position got %h want 80", bus.position); end
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
      checks++; if (bus.range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got %b want 0", bus.range_err); end
      checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL reset_signal_lost got %b want 1", bus.signal_lost); end
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_nominal;
      int nv, lat; logic [7:0] pos; logic re, sl;
      pulse(384 * D, 20, nv, lat, pos, re, sl);
      checks++; if (nv !== 1) begin errors++; $display("FAIL nominal_valid_count got %0d want 1", nv); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL nominal_latency got %0d want 3", lat); end
      checks++; if (pos !== 8'h80) begin errors++; $display("FAIL nominal_position got %h want 80", pos); end
      checks++; if (re !== 1'b0) begin errors++; $display("FAIL nominal_range_err got %b want 0", re); end
      checks++; if (sl !== 1'b0) begin errors++; $display("FAIL nominal_signal_lost got %b want 0", sl); end
      checks++; if (bus.position !== 8'h80) begin errors++; $display("FAIL nominal_hold got %h want 80", bus.position); end
   endtask

   task automatic test_endpoints;
      int ticks [4] = '{256, 511, 200, 600};
      logic [7:0] exp_pos [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
      logic exp_re [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int nv, lat; logic [7:0] pos; logic re, sl;
      for (int k = 0; k < 4; k++) begin
         pulse(ticks[k] * D, 12, nv, lat, pos, re, sl);
         checks++; if (nv !== 1) begin errors++; $display("FAIL endpoint%0d_valid_count got %0d want 1", k, nv); end
         checks++; if (pos !== exp_pos[k]) begin errors++; $display("FAIL endpoint%0d_position got %h want %h", k, pos, exp_pos[k]); end
         checks++; if (re !== exp_re[k]) begin errors++; $display("FAIL endpoint%0d_range_err got %b want %b", k, re, exp_re[k]); end
      end
   endtask

   task automatic test_rounding;
      int h [2] = '{300 * D + D / 2 - 1, 300 * D + D / 2};
      logic [7:0] exp_pos [2] = '{8'h2C, 8'h2D};
      int nv, lat; logic [7:0] pos; logic re, sl;
      for (int k = 0; k < 2; k++) begin
         pulse(h[k], 12, nv, lat, pos, re, sl);
         checks++; if (nv !== 1) begin errors++; $display("FAIL rounding%0d_valid_count got %0d want 1", k, nv); end
         checks++; if (pos !== exp_pos[k]) begin errors++; $display("FAIL rounding%0d_position got %h want %h", k, pos, exp_pos[k]); end
      end
   endtask

   task automatic test_reset_mid_pulse;
      int nv; int lat; logic [7:0] pos; logic re, sl;
      nv = 0;
      bus.pulse_in = 1'b1;
      repeat (100 * D) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (bus.position !== 8'h80) begin errors++; $display("FAIL midreset_position got %h want 80", bus.position); end
      checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL midreset_signal_lost got %b want 1", bus.signal_lost); end
      checks++; if (bus.valid !== 1'b0 || bus.range_err !== 1'b0) begin errors++; $display("FAIL midreset_flags got %b%b want 00", bus.valid, bus.range_err); end
      @(posedge clk); @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 200 * D; i++) begin
         @(posedge clk); #1;
         if (bus.valid) nv++;
      end
      bus.pulse_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus.valid) nv++;
      end
      checks++; if (nv !== 0) begin errors++; $display("FAIL midreset_spurious_valid got %0d want 0", nv); end
      pulse(320 * D, 12, nv, lat, pos, re, sl);
      checks++; if (nv !== 1) begin errors++; $display("FAIL midreset_next_valid got %0d want 1", nv); end
      checks++; if (pos !== 8'h40) begin errors++; $display("FAIL midreset_next_position got %h want 40", pos); end
   endtask

   task automatic test_glitch;
      int nv, lat; logic [7:0] pos; logic re, sl;
      bus.pulse_in = 1'b1;
      @(posedge clk); #1 bus.pulse_in = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      pulse(260 * D, 12, nv, lat, pos, re, sl);
      checks++; if (nv !== 1) begin errors++; $display("FAIL glitch_recover_valid got %0d want 1", nv); end
      checks++; if (pos !== 8'h04) begin errors++; $display("FAIL glitch_recover_position got %h want 04", pos); end
   endtask

   task automatic test_stuck;
      int nv, lat; logic [7:0] pos; logic re, sl;
      pulse(1100 * D, 20, nv, lat, pos, re, sl);
      checks++; if (nv !== 0) begin errors++; $display("FAIL stuck_valid got %0d want 0", nv); end
      repeat (TO * D) @(posedge clk);
      #1;
      checks++; if (bus.signal_lost !== 1'b1) begin errors++; $display("FAIL stuck_signal_lost got %b want 1", bus.signal_lost); end
      checks++; if (bus.position !== 8'h04) begin errors++; $display("FAIL stuck_position_hold got %h want 04", bus.position); end
      pulse(384 * D, 12, nv, lat, pos, re, sl);
      checks++; if (nv !== 1) begin errors++; $display("FAIL stuck_next_valid got %0d want 1", nv); end
      checks++; if (pos !== 8'h80) begin errors++; $display("FAIL stuck_next_position got %h want 80", pos); end
      checks++; if (sl !== 1'b0) begin errors++; $display("FAIL stuck_next_signal_lost got %b want 0", sl); end
   endtask

   task automatic test_loss;
      int nv, lat, first; logic [7:0] pos; logic re, sl;
      first = -1;
      pulse(300 * D, 3, nv, lat, pos, re, sl);
      checks++; if (nv !== 1 || lat !== 3) begin errors++; $display("FAIL loss_valid got %0d@%0d want 1@3", nv, lat); end
      for (int i = 1; i <= TO * D + 2 * D; i++) begin
         @(posedge clk); #1;
         if (bus.signal_lost && first < 0) first = i;
      end
      checks++; if (first < TO * D - D || first > TO * D + D) begin errors++; $display("FAIL loss_timeout got %0d want %0d+-%0d clocks", first, TO * D, D); end
      checks++; if (bus.position !== 8'h2C) begin errors++; $display("FAIL loss_position_hold got %h want 2c", bus.position); end
   endtask

   task automatic test_random;
      int h, l, nv, lat; logic [7:0] pos, ep; logic re, sl, er;
      for (int k = 0; k < 12; k++) begin
         h = int'($urandom_range(150 * D, 620 * D));
         l = int'($urandom_range(8, 200));
         model(h, ep, er);
         pulse(h, l, nv, lat, pos, re, sl);
         checks++; if (nv !== 1 || lat !== 3) begin errors++; $display("FAIL random%0d_valid got %0d@%0d want 1@3 h=%0d", k, nv, lat, h); end
         checks++; if (pos !== ep || re !== er) begin errors++; $display("FAIL random%0d_decode got %h/%b want %h/%b h=%0d", k, pos, re, ep, er, h); end
         checks++; if (sl !== 1'b0) begin errors++; $display("FAIL random%0d_signal_lost got %b want 0", k, sl); end
      end
   endtask

   initial begin
      bus.pulse_in = 1'b0;
      test_reset;
      test_nominal;
      test_endpoints;
      test_rounding;
      test_reset_mid_pulse;
      test_glitch;
      test_stuck;
      test_loss;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
